// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file and its storage cells.
package regfile_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int DEPTH_DEFAULT = 32;
    localparam int WR_COUNT_W    = 16;

    // One data word at the default width.
    typedef logic [WIDTH_DEFAULT-1:0] word_t;

endpackage

// File: rtl/register_file_reg.sv
// Single load-enabled storage register with synchronous clear; one per entry.
module register_file_reg
    import regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] val_d;
    logic [WIDTH-1:0] val_q;

    // Next value: hold unless this entry is being loaded.
    always_comb begin
        // NOTE: assign a default before any condition so no latch is inferred.
        val_d = val_q;
        if (en) begin
            val_d = d;
        end
    end

    // State update; clear wins over load so a write during reset is lost.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        // NOTE: entries are cleared on reset because a cleared file is observable behaviour.
        if (reset) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q;

endmodule

// File: rtl/register_file.sv
// Multi-port register file: one write port, two combinational read ports with
// write-first bypass, optional hard-wired zero entry and a saturating write counter.
module register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEFAULT,
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [WIDTH-1:0]      wd,
    input  logic [AW-1:0]         ra1,
    input  logic [AW-1:0]         ra2,
    output logic [WIDTH-1:0]      rd1,
    output logic [WIDTH-1:0]      rd2,
    output logic [WR_COUNT_W-1:0] wr_count
);

    localparam logic [WR_COUNT_W-1:0] COUNT_MAX = {WR_COUNT_W{1'b1}};

    logic [WIDTH-1:0] entries [DEPTH];
    logic [AW-1:0]    ra_arr  [2];

    logic wa_in_range;
    logic wa_is_zero_reg;
    logic wr_commit;

    logic [WR_COUNT_W-1:0] wr_count_d;
    logic [WR_COUNT_W-1:0] wr_count_q;

    // A write commits only outside reset, inside the populated range and not to a hard-wired zero.
    always_comb begin
        wa_in_range    = (32'(wa) < 32'(DEPTH));
        wa_is_zero_reg = (ZERO_REG != 0) && (wa == '0);
        wr_commit      = we && !reset && wa_in_range && !wa_is_zero_reg;
    end

    // Storage: entry 0 is a constant when hard-wired, every other entry is a register.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
            assign entries[i] = '0;
        end else begin : g_reg
            logic load_en;
            assign load_en = wr_commit && (wa == AW'(i));

            register_file_reg #(
                .WIDTH (WIDTH)
            ) u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (load_en),
                .d     (wd),
                .q     (entries[i])
            );
        end
    end

    assign ra_arr[0] = ra1;
    assign ra_arr[1] = ra2;

    // Both read ports share one structure: bounded mux plus write-first bypass.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [WIDTH-1:0] rd_val;

        // Out-of-range addresses read 0; a committing write to the same address wins.
        always_comb begin
            rd_val = '0;
            if (32'(ra_arr[p]) < 32'(DEPTH)) begin
                rd_val = entries[ra_arr[p]];
            end
            if (wr_commit && (wa == ra_arr[p])) begin
                rd_val = wd;
            end
        end
    end

    assign rd1 = g_rd[0].rd_val;
    assign rd2 = g_rd[1].rd_val;

    // Count committed writes, sticking at the maximum instead of wrapping.
    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_commit && (wr_count_q != COUNT_MAX)) begin
            wr_count_d = wr_count_q + 1'b1;
        end
    end

    // Write counter state with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;

endmodule
